clk_period_meter: RTL and testbench



---
 rtl/clk_period_meter.sv | 162 ++++++++++++++++
 tb/tb_clk_period_meter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// -----------------------------------------------------------------------------
// clk_period_meter
//
// Measures a slow clock or strobe in units of the fast system clock. The slow
// input is synchronised, its rising edges detected, and once per slow cycle the
// period and the high time of the previous window are reported with a one-cycle
// valid pulse. If no rising edge arrives for TIMEOUT fast cycles the block
// drops back to IDLE and raises a sticky timeout flag.
//
// Parameters
//   WIDTH    width of the cycle counters and of period_out / high_out
//   TIMEOUT  fast cycles without a rising edge before the input is declared
//            dead; 2 <= TIMEOUT < 2**WIDTH
//
// Ports
//   clkin       in   1      system clock, all logic on its rising edge
//   rst_n       in   1      asynchronous active-low reset
//   sig_in      in   1      slow signal, asynchronous to clkin
//   period_out  out  WIDTH  clkin cycles between the last two rising edges
//   high_out    out  WIDTH  clkin cycles sig_in was high within that period
//   valid       out  1      one-cycle pulse when period_out/high_out update
//   timeout     out  1      sticky: no rising edge for TIMEOUT cycles
//   busy        out  1      a measurement window is open
// -----------------------------------------------------------------------------
module clk_period_meter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 250000000
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period_out,
    output logic [WIDTH-1:0] high_out,
    output logic             valid,
    output logic             timeout,
    output logic             busy
);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    // Counter value in the last cycle of a window that may still end in a
    // rise; one cycle later the input is considered dead.
    localparam logic [WIDTH-1:0] L_CNT_LAST = WIDTH'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] L_ONE      = WIDTH'(1);

    // Input conditioning
    logic             r_meta;
    logic             r_sync;
    logic             r_prev;
    logic             w_rise;
    logic [WIDTH-1:0] w_sync_ext;

    // Measurement state
    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_hcnt;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_high;
    logic             r_valid;
    logic             r_timeout;

    // Next-state values
    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_hcnt_nxt;
    logic [WIDTH-1:0] w_period_nxt;
    logic [WIDTH-1:0] w_high_nxt;
    logic             w_valid_nxt;
    logic             w_timeout_nxt;

    assign w_rise     = r_sync & ~r_prev;
    assign w_sync_ext = WIDTH'(r_sync);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hcnt_nxt    = r_hcnt;
        w_period_nxt  = r_period;
        w_high_nxt    = r_high;
        w_valid_nxt   = 1'b0;
        w_timeout_nxt = r_timeout;

        case (r_state)
            IDLE: begin
                // The first edge only opens a window; there is nothing to
                // report yet, and a pending timeout stays visible.
                if (w_rise) begin
                    w_state_nxt = MEASURE;
                    w_cnt_nxt   = '0;
                    w_hcnt_nxt  = '0;
                end
            end

            MEASURE: begin
                if (w_rise) begin
                    // The rise cycle itself closes this window, hence the +1
                    // and the current s_sync sample; a rise on the limit
                    // cycle is still a valid measurement.
                    w_period_nxt  = r_cnt + L_ONE;
                    w_high_nxt    = r_hcnt + w_sync_ext;
                    w_valid_nxt   = 1'b1;
                    w_timeout_nxt = 1'b0;
                    w_cnt_nxt     = '0;
                    w_hcnt_nxt    = '0;
                end else if (r_cnt == L_CNT_LAST) begin
                    w_state_nxt   = IDLE;
                    w_timeout_nxt = 1'b1;
                    w_period_nxt  = '0;
                    w_high_nxt    = '0;
                    w_cnt_nxt     = '0;
                    w_hcnt_nxt    = '0;
                end else begin
                    w_cnt_nxt  = r_cnt + L_ONE;
                    w_hcnt_nxt = r_hcnt + w_sync_ext;
                end
            end

            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_meta    <= 1'b0;
            r_sync    <= 1'b0;
            r_prev    <= 1'b0;
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_hcnt    <= '0;
            r_period  <= '0;
            r_high    <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value, which is what keeps the two synchroniser stages
            // and the edge register three distinct pipeline steps.
            r_meta    <= sig_in;
            r_sync    <= r_meta;
            r_prev    <= r_sync;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hcnt    <= w_hcnt_nxt;
            r_period  <= w_period_nxt;
            r_high    <= w_high_nxt;
            r_valid   <= w_valid_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign period_out = r_period;
    assign high_out   = r_high;
    assign valid      = r_valid;
    assign timeout    = r_timeout;
    assign busy       = (r_state == MEASURE);

endmodule

// File: tb/tb_clk_period_meter.sv
// -----------------------------------------------------------------------------
// tb_clk_period_meter
//
// Directed sequence with randomised pulse shapes. sig_in is driven on falling
// clkin edges; each generated rising edge is logged with the index of the
// first clkin edge that sees it, together with the length of its high phase.
// The expected result of a window is then plain arithmetic on that log:
// period = distance between consecutive rising edges, high = length of the
// high phase opening the window, valid at a fixed offset after the closing
// edge. A monitor logs every valid pulse observed on the DUT.
// -----------------------------------------------------------------------------
module tb_clk_period_meter;

    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 64;
    // Edges between the first clkin edge that sees sig_in high and the edge
    // that registers the resulting measurement (synchroniser + edge register).
    localparam int LAT     = 2;

    typedef struct {
        int cyc;
        int per;
        int hi;
    } ev_t;

    logic             clkin = 1'b0;
    logic             rst_n = 1'b0;
    logic             sig_in = 1'b0;
    logic [WIDTH-1:0] period_out;
    logic [WIDTH-1:0] high_out;
    logic             valid;
    logic             timeout;
    logic             busy;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   rise_q[$];
    int   hi_q[$];
    ev_t  obs_q[$];
    ev_t  mon_ev;

    clk_period_meter #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clkin      (clkin),
        .rst_n      (rst_n),
        .sig_in     (sig_in),
        .period_out (period_out),
        .high_out   (high_out),
        .valid      (valid),
        .timeout    (timeout),
        .busy       (busy)
    );

    always #5 clkin = ~clkin;

    always @(posedge clkin) cyc <= cyc + 1;

    // Log every valid pulse with the edge index that produced it.
    always @(posedge clkin) begin
        #1;
        if (valid === 1'b1) begin
            mon_ev.cyc = cyc;
            mon_ev.per = int'(period_out);
            mon_ev.hi  = int'(high_out);
            obs_q.push_back(mon_ev);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected finish within budget");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One rising edge of sig_in followed by hi high and lo low clkin cycles.
    // Called and returning on a falling clkin edge.
    task automatic pulse(input int hi, input int lo);
        sig_in = 1'b1;
        rise_q.push_back(cyc + 1);
        hi_q.push_back(hi);
        repeat (hi) @(negedge clkin);
        sig_in = 1'b0;
        repeat (lo) @(negedge clkin);
    endtask

    // Compare every completed window in the rise log against the valid log.
    // The latest rise stays in the log as the start of the open window.
    task automatic check_windows(input string tag);
        int  exp_cyc;
        int  exp_per;
        int  exp_hi;
        ev_t e;
        while (rise_q.size() >= 2) begin
            exp_per = rise_q[1] - rise_q[0];
            exp_hi  = hi_q[0];
            exp_cyc = rise_q[1] + LAT;
            void'(rise_q.pop_front());
            void'(hi_q.pop_front());
            check({tag, "_valid_seen"}, (obs_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (obs_q.size() > 0) begin
                e = obs_q.pop_front();
                check({tag, "_valid_cycle"}, e.cyc, exp_cyc);
                check({tag, "_period"},      e.per, exp_per);
                check({tag, "_high"},        e.hi,  exp_hi);
            end
        end
        check({tag, "_no_extra_valid"}, obs_q.size(), 0);
    endtask

    initial begin
        int hi;
        int lo;
        int tgt;

        // ---- reset with sig_in toggling, release while sig_in is high ----
        repeat (2) @(negedge clkin);
        for (int i = 0; i < 6; i++) begin
            @(negedge clkin);
            sig_in = ~sig_in;
        end
        check("rst_period",  period_out, 0);
        check("rst_high",    high_out,   0);
        check("rst_valid",   valid,      0);
        check("rst_timeout", timeout,    0);
        check("rst_busy",    busy,       0);
        @(negedge clkin);
        sig_in = 1'b1;
        @(negedge clkin);
        rst_n = 1'b1;
        // The first edge after release sees sig_in high: that is the arming rise.
        rise_q.push_back(cyc + 1);
        hi_q.push_back(5);
        @(negedge clkin);
        check("arm_busy_e0", busy, 0);
        @(negedge clkin);
        check("arm_busy_e1", busy, 0);
        @(negedge clkin);
        check("arm_busy_e2", busy, 1);
        check("arm_no_valid", valid, 0);
        repeat (2) @(negedge clkin);
        sig_in = 1'b0;
        repeat (5) @(negedge clkin);

        // ---- square wave 5/5 ----
        repeat (5) pulse(5, 5);
        check_windows("sq");
        check("sq_hold_period", period_out, 10);
        check("sq_hold_high",   high_out,   5);

        // ---- duty change 3/13 ----
        repeat (4) pulse(3, 13);
        check_windows("duty");
        check("duty_hold_period", period_out, 16);
        check("duty_hold_high",   high_out,   3);

        // ---- random shapes within the timeout limit ----
        repeat (8) begin
            hi = $urandom_range(25, 2);
            lo = $urandom_range(25, 2);
            pulse(hi, lo);
        end
        check_windows("rnd");

        // ---- stop toggling: timeout exactly TIMEOUT cycles after last rise ----
        tgt = rise_q[rise_q.size() - 1] + LAT + TIMEOUT;
        while (cyc < tgt - 1) @(negedge clkin);
        check("pre_to_timeout", timeout, 0);
        check("pre_to_busy",    busy,    1);
        @(negedge clkin);
        check("to_timeout", timeout,    1);
        check("to_busy",    busy,       0);
        check("to_period",  period_out, 0);
        check("to_high",    high_out,   0);
        check("to_valid",   valid,      0);
        rise_q.delete();
        hi_q.delete();
        repeat (20) @(negedge clkin);
        check("to_sticky", timeout, 1);
        check_windows("stop");

        // ---- resume: first rise re-arms only, second one reports ----
        pulse(4, 6);
        check("resume_arm_timeout", timeout, 1);
        check("resume_arm_busy",    busy,    1);
        check_windows("resume_arm");
        pulse(4, 6);
        check("resume_timeout_clr", timeout, 0);
        check_windows("resume");

        // ---- boundary: period exactly TIMEOUT ----
        repeat (3) pulse(32, 32);
        check("bound_timeout", timeout, 0);
        check("bound_busy",    busy,    1);
        check_windows("bound");
        sig_in = 1'b1;
        rise_q.push_back(cyc + 1);
        hi_q.push_back(32);
        repeat (10) @(negedge clkin);
        check_windows("bound_last");

        // ---- reset mid-window discards it ----
        rst_n = 1'b0;
        #1;
        check("midrst_period",  period_out, 0);
        check("midrst_high",    high_out,   0);
        check("midrst_valid",   valid,      0);
        check("midrst_timeout", timeout,    0);
        check("midrst_busy",    busy,       0);
        rise_q.delete();
        hi_q.delete();
        for (int i = 0; i < 8; i++) begin
            @(negedge clkin);
            sig_in = ~sig_in;
        end
        check("midrst_hold_period", period_out, 0);
        check_windows("midrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
